instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DEPTH, default 32, instruction memory words loadable (1..256).
REQ-002 Parameter TIMEOUT, default 255, consecutive stall cycles before abort.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  single-cycle request to begin a load.
REQ-006 In_Valid  input  1  byte-stream valid.
REQ-007 In_Data  input  8  byte-stream payload.
REQ-008 In_Ready  output  1  loader accepts a byte this cycle.
REQ-009 Mem_WrEn  output  1  instruction memory write strobe.
REQ-010 Mem_WrAddr  output  8  instruction memory write address.
REQ-011 Mem_WrData  output  8  instruction word written.
REQ-012 Cpu_Hold  output  1  holds the processor (PC and register file) in reset while high.
REQ-013 Load_Done  output  1  sticky: last load completed with a good checksum.
REQ-014 Load_Err  output  1  sticky: last load failed.

Function
REQ-015 Frame format SHALL be: length byte L, then L instruction bytes, then checksum byte equal to the XOR of the L instruction bytes.
REQ-016 A byte SHALL be accepted only on a cycle with In_Valid=1 and In_Ready=1; In_Data is ignored otherwise.
REQ-017 States SHALL be IDLE, LEN, DATA, CSUM, DONE, ERR; In_Ready=1 only in LEN, DATA, CSUM.
REQ-018 IDLE/DONE/ERR: Start=1 SHALL go to LEN, clear Load_Done and Load_Err, set Cpu_Hold=1 on the next cycle, zero the address, checksum and stall counters.
REQ-019 Start SHALL be ignored in LEN, DATA, CSUM.
REQ-020 LEN: accepted L with L=0 or L>DEPTH SHALL go to ERR; otherwise latch L and go to DATA.
REQ-021 DATA: each accepted byte SHALL produce exactly one Mem_WrEn pulse on the following cycle with Mem_WrAddr = byte index (0..L-1) and Mem_WrData = that byte; one write per cycle sustained under back-to-back input.
REQ-022 DATA: the running checksum SHALL XOR each accepted byte; after the L-th byte go to CSUM.
REQ-023 CSUM: accepted byte equal to running checksum SHALL go to DONE, else ERR; no memory write occurs in CSUM.
REQ-024 DONE: Load_Done=1, Cpu_Hold=0, processor released.
REQ-025 ERR: Load_Err=1, Cpu_Hold stays 1, no further writes until next Start.
REQ-026 Stall counter SHALL count cycles in LEN/DATA/CSUM without an accepted byte, clear on every accepted byte, and force ERR on the cycle it reaches TIMEOUT.
REQ-027 Mem_WrEn SHALL be 0 in every cycle not specified by REQ-021; Mem_WrAddr/Mem_WrData hold last values when Mem_WrEn=0.

Reset
REQ-028 Reset=0 SHALL immediately force IDLE and In_Ready, Mem_WrEn, Mem_WrAddr, Mem_WrData, Cpu_Hold, Load_Done, Load_Err, all counters and checksum to 0, including mid-load.
REQ-029 After Reset deasserts, the block SHALL stay in IDLE until Start.

Structure
REQ-030 State encoding, frame-field constants and DEPTH/TIMEOUT defaults SHALL live in a shared loader package.
REQ-031 The stall counter SHALL be one sub-module, loader_stall_timer (inputs: clear, count enable; output: expired).
REQ-032 All outputs SHALL be driven from registers.

Verification
REQ-033 Start, L=3, bytes 0x41,0x82,0xC3, checksum 0x00 -> writes (0,0x41),(1,0x82),(2,0xC3) on consecutive cycles, Load_Done=1, Cpu_Hold falls to 0.
REQ-034 Same frame with checksum 0xFF -> three writes, Load_Err=1, Load_Done=0, Cpu_Hold remains 1.
REQ-035 L=0, then separately L=33 (DEPTH=32) -> Load_Err=1, zero Mem_WrEn pulses.
REQ-036 L=4, two data bytes, then In_Valid=0 for 255 cycles -> ERR entered on the 255th stall cycle, exactly two writes.
REQ-037 Reset=0 during DATA after write to address 1 -> all outputs 0 without a clock edge; new Start and L=1 byte 0x7E checksum 0x7E -> single write (0,0x7E), Load_Done=1.
REQ-038 Start pulsed mid-DATA and In_Valid held high with In_Ready=0 in IDLE -> no state change, no writes.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the state encoding, frame-field constants and parameter defaults.
package instr_mem_loader_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned ADDR_W          = 8;
    localparam int unsigned STALL_W         = 16;
    localparam int unsigned DEPTH_DEFAULT   = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Smallest legal frame length and the checksum seed (XOR identity).
    localparam logic [BYTE_W-1:0] LEN_MIN   = 8'd1;
    localparam logic [BYTE_W-1:0] CSUM_INIT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } mem_wr_t;

    function automatic logic len_ok(input logic [BYTE_W-1:0] len, input int unsigned depth);
        return (len >= LEN_MIN) && (32'(len) <= depth);
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface instr_mem_loader_if;
    import instr_mem_loader_pkg::*;

    logic              valid;
    logic [BYTE_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/loader_stall_timer.sv
// Counts idle cycles of an active load; expires on the cycle the count reaches TIMEOUT.
module loader_stall_timer
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_c
);

    logic [STALL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + STALL_W'(1);
        end
    end

    // Flags the stall cycle that brings the count up to TIMEOUT, so the FSM leaves on that edge.
    assign expired_c = count_en_i && !clear_i && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length/data/checksum byte frame into instruction memory while holding the CPU.
// The CPU is released only after a frame whose XOR checksum matches.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    instr_mem_loader_if.slave in_if,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [BYTE_W-1:0] mem_wr_data_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
    mem_wr_t           wr_q, wr_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    logic accept, start_go, last_byte;
    logic stall_clr, stall_en, stall_exp;

    // ready_q mirrors "state is LEN/DATA/CSUM", so it doubles as the busy flag.
    assign accept    = in_if.valid && ready_q;
    assign start_go  = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign last_byte = (idx_q == ADDR_W'(len_q - BYTE_W'(1)));
    assign stall_clr = start_go || accept;
    assign stall_en  = ready_q && !accept;

    loader_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (stall_clr),
        .count_en_i (stall_en),
        .expired_c  (stall_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept)         state_d = len_ok(in_if.data, DEPTH) ? ST_DATA : ST_ERR;
                else if (stall_exp) state_d = ST_ERR;
            end
            ST_DATA: begin
                if (accept && last_byte) state_d = ST_CSUM;
                else if (stall_exp)      state_d = ST_ERR;
            end
            ST_CSUM: begin
                if (accept)         state_d = (in_if.data == csum_q) ? ST_DONE : ST_ERR;
                else if (stall_exp) state_d = ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        wr_d    = wr_q;
        wr_d.en = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        ready_d = state_d inside {ST_LEN, ST_DATA, ST_CSUM};

        if (start_go) begin
            len_d  = '0;
            idx_d  = '0;
            csum_d = CSUM_INIT;
            hold_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (accept && (state_q == ST_LEN)) begin
            len_d = in_if.data;
        end
        if (accept && (state_q == ST_DATA)) begin
            wr_d.en   = 1'b1;
            wr_d.addr = idx_q;
            wr_d.data = in_if.data;
            idx_d     = idx_q + ADDR_W'(1);
            csum_d    = csum_q ^ in_if.data;
        end
        // Hold stays asserted on error so the CPU never runs a partial image.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            wr_q    <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            wr_q    <= wr_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign in_if.ready   = ready_q;
    assign mem_wr_en_o   = wr_q.en;
    assign mem_wr_addr_o = wr_q.addr;
    assign mem_wr_data_o = wr_q.data;
    assign cpu_hold_o    = hold_q;
    assign load_done_o   = done_q;
    assign load_err_o    = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed frame table, corner sequences,
// and random frames checked against a frame-level reference model.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 255;
    localparam int LOG_N   = 4096;
    localparam int NVEC    = 7;
    localparam int NRAND   = 30;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       hold;
    logic       done;
    logic       err;

    instr_mem_loader_if bus();

    instr_mem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .in_if         (bus),
        .mem_wr_en_o   (wr_en),
        .mem_wr_addr_o (wr_addr),
        .mem_wr_data_o (wr_data),
        .cpu_hold_o    (hold),
        .load_done_o   (done),
        .load_err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe seen at the falling edge is logged with its cycle number.
    int         cyc = 0;
    int         wr_cnt = 0;
    logic [7:0] log_a [LOG_N];
    logic [7:0] log_d [LOG_N];
    int         log_c [LOG_N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_a[wr_cnt % LOG_N] <= wr_addr;
            log_d[wr_cnt % LOG_N] <= wr_data;
            log_c[wr_cnt % LOG_N] <= cyc;
            wr_cnt                <= wr_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        ok = 1'b0;
        bus.valid = 1'b0;
        repeat (gap) tick();
        bus.valid = 1'b1;
        bus.data  = b;
        for (int k = 0; k < TIMEOUT + 16 && !ok; k++) begin
            if (bus.ready === 1'b1) ok = 1'b1;
            tick();
        end
        bus.valid = 1'b0;
        check("byte_accepted", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_hold_after_start"}, 32'(hold), 32'd1);
        check({tag, "_done_cleared"}, 32'(done), 32'd0);
        check({tag, "_err_cleared"}, 32'(err), 32'd0);
        check({tag, "_ready_in_len"}, 32'(bus.ready), 32'd1);
    endtask

    task automatic check_outcome(input string tag, input logic e_done, input logic e_err, input logic e_hold);
        check({tag, "_load_done"}, 32'(done), 32'(e_done));
        check({tag, "_load_err"}, 32'(err), 32'(e_err));
        check({tag, "_cpu_hold"}, 32'(hold), 32'(e_hold));
        check({tag, "_ready_idle"}, 32'(bus.ready), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int base, input logic [7:0] exp_d[$], input bit consec);
        check({tag, "_write_count"}, 32'(wr_cnt - base), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < wr_cnt - base; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(log_a[(base + i) % LOG_N]), 32'(i));
            check($sformatf("%s_data%0d", tag, i), 32'(log_d[(base + i) % LOG_N]), 32'(exp_d[i]));
            if (consec && i > 0)
                check($sformatf("%s_cycle%0d", tag, i),
                      32'(log_c[(base + i) % LOG_N] - log_c[base % LOG_N]), 32'(i));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_hold"}, 32'(hold), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    typedef struct {
        logic [7:0]      len;
        logic [0:3][7:0] d;
        logic [7:0]      csum;
        int              n_wr;
        logic            exp_done;
        logic            exp_err;
        logic            exp_hold;
    } vec_t;

    vec_t       vecs [NVEC];
    int         base;
    logic [7:0] q  [$];
    logic [7:0] fr [$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not reach the end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{len:8'd3,  d:{8'h41, 8'h82, 8'hC3, 8'h00}, csum:8'h00, n_wr:3, exp_done:1'b1, exp_err:1'b0, exp_hold:1'b0};
        vecs[1] = '{len:8'd3,  d:{8'h41, 8'h82, 8'hC3, 8'h00}, csum:8'hFF, n_wr:3, exp_done:1'b0, exp_err:1'b1, exp_hold:1'b1};
        vecs[2] = '{len:8'd0,  d:{8'h11, 8'h22, 8'h33, 8'h44}, csum:8'h00, n_wr:0, exp_done:1'b0, exp_err:1'b1, exp_hold:1'b1};
        vecs[3] = '{len:8'd33, d:{8'h11, 8'h22, 8'h33, 8'h44}, csum:8'h00, n_wr:0, exp_done:1'b0, exp_err:1'b1, exp_hold:1'b1};
        vecs[4] = '{len:8'd1,  d:{8'h7E, 8'h00, 8'h00, 8'h00}, csum:8'h7E, n_wr:1, exp_done:1'b1, exp_err:1'b0, exp_hold:1'b0};
        vecs[5] = '{len:8'd4,  d:{8'h01, 8'h02, 8'h04, 8'h08}, csum:8'h0F, n_wr:4, exp_done:1'b1, exp_err:1'b0, exp_hold:1'b0};
        vecs[6] = '{len:8'd4,  d:{8'h10, 8'h20, 8'h30, 8'h40}, csum:8'h41, n_wr:4, exp_done:1'b0, exp_err:1'b1, exp_hold:1'b1};

        rst_n     = 1'b1;
        start     = 1'b0;
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        #1 rst_n  = 1'b0;
        #2;
        check_all_zero("reset");
        #19 rst_n = 1'b1;
        tick();

        // Idle after reset: valid held high must not be accepted or move the FSM.
        base = wr_cnt;
        bus.valid = 1'b1;
        bus.data  = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("idle_ready_%0d", i), 32'(bus.ready), 32'd0);
        end
        bus.valid = 1'b0;
        check("idle_no_writes", 32'(wr_cnt - base), 32'd0);
        check("idle_hold", 32'(hold), 32'd0);

        // Start pulsed mid-DATA is ignored.
        base = wr_cnt;
        pulse_start("midstart");
        send_byte(8'd4, 0);
        send_byte(8'h5C, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midstart_still_ready", 32'(bus.ready), 32'd1);
        send_byte(8'h3A, 0);
        send_byte(8'hC5, 0);
        send_byte(8'h81, 0);
        send_byte(8'h5C ^ 8'h3A ^ 8'hC5 ^ 8'h81, 0);
        tick();
        check_outcome("midstart", 1'b1, 1'b0, 1'b0);
        q = '{8'h5C, 8'h3A, 8'hC5, 8'h81};
        check_writes("midstart", base, q, 1'b0);

        for (int v = 0; v < NVEC; v++) begin
            base = wr_cnt;
            q.delete();
            pulse_start($sformatf("vec%0d", v));
            send_byte(vecs[v].len, 0);
            if (vecs[v].n_wr > 0) begin
                for (int i = 0; i < vecs[v].n_wr; i++) begin
                    send_byte(vecs[v].d[i], 0);
                    q.push_back(vecs[v].d[i]);
                end
                send_byte(vecs[v].csum, 0);
            end
            tick();
            check_outcome($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_hold);
            check_writes($sformatf("vec%0d", v), base, q, 1'b1);
        end

        // Stall timeout: two bytes of a 4-byte frame then silence.
        base = wr_cnt;
        pulse_start("stall");
        send_byte(8'd4, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (TIMEOUT - 1) tick();
        check("stall_err_before_limit", 32'(err), 32'd0);
        check("stall_ready_before_limit", 32'(bus.ready), 32'd1);
        tick();
        check_outcome("stall", 1'b0, 1'b1, 1'b1);
        bus.valid = 1'b1;
        bus.data  = 8'h33;
        repeat (3) tick();
        bus.valid = 1'b0;
        q = '{8'h11, 8'h22};
        check_writes("stall", base, q, 1'b1);

        // Asynchronous reset in the middle of DATA, then a clean one-byte load.
        pulse_start("rstmid");
        send_byte(8'd4, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        check("rstmid_write_addr1", 32'(wr_addr), 32'd1);
        #6 rst_n = 1'b0;
        #1;
        check_all_zero("rstmid");
        #6 rst_n = 1'b1;
        tick();
        base = wr_cnt;
        bus.valid = 1'b1;
        repeat (4) tick();
        bus.valid = 1'b0;
        check("post_reset_ready", 32'(bus.ready), 32'd0);
        check("post_reset_no_writes", 32'(wr_cnt - base), 32'd0);
        pulse_start("reload");
        send_byte(8'd1, 0);
        send_byte(8'h7E, 0);
        send_byte(8'h7E, 0);
        tick();
        check_outcome("reload", 1'b1, 1'b0, 1'b0);
        q = '{8'h7E};
        check_writes("reload", base, q, 1'b1);

        // Random frames against a frame-level model.
        for (int f = 0; f < NRAND; f++) begin
            int         len;
            int         nsend;
            logic [7:0] x;
            logic [7:0] cs;
            logic       len_good;
            logic       e_done;
            len = (f == 0) ? DEPTH : int'($urandom_range(0, 36));
            fr.delete();
            q.delete();
            x = 8'h00;
            fr.push_back(8'(len));
            for (int i = 0; i < len; i++) begin
                fr.push_back(8'($urandom));
                x = x ^ fr[i + 1];
            end
            cs = ($urandom_range(0, 2) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
            fr.push_back(cs);
            len_good = (len >= 1) && (len <= DEPTH);
            e_done   = len_good && (cs == x);
            nsend    = len_good ? len + 2 : 1;
            if (len_good)
                for (int i = 0; i < len; i++) q.push_back(fr[i + 1]);

            base = wr_cnt;
            pulse_start($sformatf("rand%0d", f));
            for (int i = 0; i < nsend; i++) send_byte(fr[i], int'($urandom_range(0, 2)));
            tick();
            check_outcome($sformatf("rand%0d", f), e_done, !e_done, !e_done);
            check_writes($sformatf("rand%0d", f), base, q, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
